// File: rtl/mod_vga_timing_encoder.sv
// Purpose : VGA raster timing generator; issues pixel coordinates upstream and realigns returned colour with sync/DE.
// Latency : PIPE_LAT+1 enabled pixel cycles from out_vga_next_x/y to the matching pixel on out_vga_*.
// Backpr. : none; the raster free-runs on in_pix_ce, and the upstream source must answer in exactly PIPE_LAT enabled cycles.
//
// Ports:
//   in_clk, in_rst_n          pixel clock, asynchronous active-low reset
//   in_pix_ce                 pixel clock enable; every piece of state advances only while high
//   in_vga_r/g/b              colour for the coordinate issued PIPE_LAT enabled cycles earlier
//   in_test_pattern           selects internal colour bars (only when VGA_TEST_PATTERN_EN is defined)
//   out_vga_r/g/b             registered colour, forced to 0 outside the active area
//   out_vga_hsync/vsync/de    sync and data-enable aligned with out_vga_r/g/b
//   out_vga_next_x/y          coordinate currently requested from upstream
//   out_vga_next_active       requested coordinate lies inside the visible area
//   out_line_start            one-cycle pulse on an enabled cycle at x==0
//   out_frame_start           one-cycle pulse on an enabled cycle at (0,0)
//
// Optional feature: define VGA_TEST_PATTERN_EN to build in 8 vertical colour bars.
// When it is not defined, in_test_pattern is ignored.
// Legal PIPE_LAT range is 0..7.

module mod_vga_timing_encoder #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int COLOR_W   = 8,
    parameter int PIPE_LAT  = 1
) (
    input  logic               in_clk,
    input  logic               in_rst_n,
    input  logic               in_pix_ce,
    input  logic [COLOR_W-1:0] in_vga_r,
    input  logic [COLOR_W-1:0] in_vga_g,
    input  logic [COLOR_W-1:0] in_vga_b,
    input  logic               in_test_pattern,
    output logic [COLOR_W-1:0] out_vga_r,
    output logic [COLOR_W-1:0] out_vga_g,
    output logic [COLOR_W-1:0] out_vga_b,
    output logic               out_vga_hsync,
    output logic               out_vga_vsync,
    output logic               out_vga_de,
    output logic [11:0]        out_vga_next_x,
    output logic [11:0]        out_vga_next_y,
    output logic               out_vga_next_active,
    output logic               out_frame_start,
    output logic               out_line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
    localparam logic [11:0] H_LAST_C = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_SYN_LO = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYN_HI = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
    localparam logic [11:0] V_LAST_C = 12'(V_TOTAL - 1);
    localparam logic [11:0] V_SYN_LO = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYN_HI = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        active_cur;
    logic        hsync_cur;
    logic        vsync_cur;
    logic        act_gate;

    // Stage i holds the value for the coordinate issued i+1 enabled cycles ago.
    logic [PIPE_LAT:0] hs_sr;
    logic [PIPE_LAT:0] vs_sr;
    logic [PIPE_LAT:0] act_sr;

    logic [COLOR_W-1:0] src_r;
    logic [COLOR_W-1:0] src_g;
    logic [COLOR_W-1:0] src_b;

    // Raster counters
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else if (in_pix_ce) begin
            if (h_cnt == H_LAST_C) begin
                h_cnt <= 12'd0;
                v_cnt <= (v_cnt == V_LAST_C) ? 12'd0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end
        end
    end

    always_comb begin
        active_cur = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        hsync_cur  = ((h_cnt >= H_SYN_LO) && (h_cnt <= H_SYN_HI)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_cur  = ((v_cnt >= V_SYN_LO) && (v_cnt <= V_SYN_HI)) ? VSYNC_POL : ~VSYNC_POL;
    end

    // The counters sit at (0,0) during reset, which would otherwise look like
    // an active, line-starting coordinate; reset masks these combinational outputs.
    assign out_vga_next_x      = h_cnt;
    assign out_vga_next_y      = v_cnt;
    assign out_vga_next_active = in_rst_n & active_cur;
    assign out_line_start      = in_rst_n & in_pix_ce & (h_cnt == 12'd0);
    assign out_frame_start     = out_line_start & (v_cnt == 12'd0);

    // Sync/active delay line
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            hs_sr  <= {(PIPE_LAT+1){~HSYNC_POL}};
            vs_sr  <= {(PIPE_LAT+1){~VSYNC_POL}};
            act_sr <= '0;
        end else if (in_pix_ce) begin
            hs_sr[0]  <= hsync_cur;
            vs_sr[0]  <= vsync_cur;
            act_sr[0] <= active_cur;
            for (int i = 1; i <= PIPE_LAT; i++) begin
                hs_sr[i]  <= hs_sr[i-1];
                vs_sr[i]  <= vs_sr[i-1];
                act_sr[i] <= act_sr[i-1];
            end
        end
    end

    // Colour arriving now belongs to the coordinate issued PIPE_LAT cycles ago,
    // i.e. one stage short of the output end of the delay line.
    generate
        if (PIPE_LAT == 0) begin : g_gate_lat0
            assign act_gate = active_cur;
        end else begin : g_gate_latn
            assign act_gate = act_sr[PIPE_LAT-1];
        end
    endgenerate

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_cur;
    logic [2:0] bar_gate;

    // Bar index = number of bar boundaries at or left of the current x.
    always_comb begin
        bar_cur = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h_cnt >= 12'(i * BAR_W)) begin
                bar_cur = 3'(i);
            end
        end
    end

    // Delay the bar index like the upstream source delays its colour, so the
    // pattern and the external path share the same latency.
    generate
        if (PIPE_LAT == 0) begin : g_bar_lat0
            assign bar_gate = bar_cur;
        end else begin : g_bar_latn
            logic [PIPE_LAT-1:0][2:0] bar_sr;
            always_ff @(posedge in_clk or negedge in_rst_n) begin
                if (!in_rst_n) begin
                    bar_sr <= '0;
                end else if (in_pix_ce) begin
                    bar_sr[0] <= bar_cur;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        bar_sr[i] <= bar_sr[i-1];
                    end
                end
            end
            assign bar_gate = bar_sr[PIPE_LAT-1];
        end
    endgenerate

    // Bar order white, yellow, cyan, green, magenta, red, blue, black:
    // red is on when bit1 is clear, green when bit2 is clear, blue when bit0 is clear.
    always_comb begin
        if (in_test_pattern) begin
            src_r = {COLOR_W{~bar_gate[1]}};
            src_g = {COLOR_W{~bar_gate[2]}};
            src_b = {COLOR_W{~bar_gate[0]}};
        end else begin
            src_r = in_vga_r;
            src_g = in_vga_g;
            src_b = in_vga_b;
        end
    end
`else
    logic unused_test_pattern;
    assign unused_test_pattern = in_test_pattern;

    always_comb begin
        src_r = in_vga_r;
        src_g = in_vga_g;
        src_b = in_vga_b;
    end
`endif

    // Output colour register; blanking forces black
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_vga_r <= '0;
            out_vga_g <= '0;
            out_vga_b <= '0;
        end else if (in_pix_ce) begin
            out_vga_r <= act_gate ? src_r : '0;
            out_vga_g <= act_gate ? src_g : '0;
            out_vga_b <= act_gate ? src_b : '0;
        end
    end

    assign out_vga_hsync = hs_sr[PIPE_LAT];
    assign out_vga_vsync = vs_sr[PIPE_LAT];
    assign out_vga_de    = act_sr[PIPE_LAT];

endmodule

// File: tb/tb_mod_vga_timing_encoder.sv
module tb_mod_vga_timing_encoder;

    // DUT A: small raster, mixed sync polarity, PIPE_LAT=3
    localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
    localparam int LAT = 3;
    localparam bit HPOL = 1'b1, VPOL = 1'b0;
    localparam int N_CYC = 3000;
    localparam int RST_AT = 1400;

    typedef struct packed {
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] nx;
        logic [11:0] ny;
        logic        na;
        logic        fs;
        logic        ls;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0, ce = 1'b0, tp = 1'b0;
    logic [7:0] r_in = '0, g_in = '0, b_in = '0;
    logic [7:0] a_r, a_g, a_b;
    logic       a_hs, a_vs, a_de, a_na, a_fs, a_ls;
    logic [11:0] a_nx, a_ny;

    logic       rst_b_n = 1'b0;
    logic [7:0] b_r, b_g, b_b;
    logic       b_hs, b_vs, b_de, b_na, b_fs, b_ls;
    logic [11:0] b_nx, b_ny;

    int   n_chk = 0;
    int   n_fail = 0;
    bit   done_b = 1'b0;
    exp_t q[$];

    logic [7:0] g_hist [0:4095];
    logic [7:0] b_hist [0:4095];
    logic       tp_hist[0:4095];

    mod_vga_timing_encoder #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .COLOR_W(8), .PIPE_LAT(LAT)
    ) dut_a (
        .in_clk(clk), .in_rst_n(rst_n), .in_pix_ce(ce),
        .in_vga_r(r_in), .in_vga_g(g_in), .in_vga_b(b_in),
        .in_test_pattern(tp),
        .out_vga_r(a_r), .out_vga_g(a_g), .out_vga_b(a_b),
        .out_vga_hsync(a_hs), .out_vga_vsync(a_vs), .out_vga_de(a_de),
        .out_vga_next_x(a_nx), .out_vga_next_y(a_ny),
        .out_vga_next_active(a_na), .out_frame_start(a_fs), .out_line_start(a_ls)
    );

    // DUT B: default 640x480 timing, enable tied high
    mod_vga_timing_encoder dut_b (
        .in_clk(clk), .in_rst_n(rst_b_n), .in_pix_ce(1'b1),
        .in_vga_r(8'h00), .in_vga_g(8'h00), .in_vga_b(8'h00),
        .in_test_pattern(1'b0),
        .out_vga_r(b_r), .out_vga_g(b_g), .out_vga_b(b_b),
        .out_vga_hsync(b_hs), .out_vga_vsync(b_vs), .out_vga_de(b_de),
        .out_vga_next_x(b_nx), .out_vga_next_y(b_ny),
        .out_vga_next_active(b_na), .out_frame_start(b_fs), .out_line_start(b_ls)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t x;
        x    = '0;
        x.hs = ~HPOL;
        x.vs = ~VPOL;
        return x;
    endfunction

    // Expected outputs after e enabled edges since reset release, with enable c this cycle.
    function automatic exp_t model(int e, bit c);
        exp_t x;
        int   m, h, v, bar;
        x    = reset_exp();
        x.nx = 12'(e % HT);
        x.ny = 12'((e / HT) % VT);
        x.na = ((e % HT) < HA) && (((e / HT) % VT) < VA);
        x.ls = c && ((e % HT) == 0);
        x.fs = x.ls && (((e / HT) % VT) == 0);
        m = e - LAT - 1;
        if (m >= 0) begin
            h = m % HT;
            v = (m / HT) % VT;
            x.de = (h < HA) && (v < VA);
            if (h >= HA + HF && h < HA + HF + HS) x.hs = HPOL;
            if (v >= VA + VF && v < VA + VF + VS) x.vs = VPOL;
            if (x.de) begin
                x.r = 8'(h);
                x.g = g_hist[e-1];
                x.b = b_hist[e-1];
`ifdef VGA_TEST_PATTERN_EN
                if (tp_hist[e-1]) begin
                    bar = h / (HA / 8);
                    x.r = (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? 8'hFF : 8'h00;
                    x.g = (bar <= 3) ? 8'hFF : 8'h00;
                    x.b = (bar == 0 || bar == 2 || bar == 4 || bar == 6) ? 8'hFF : 8'h00;
                end
`endif
            end
        end
        return x;
    endfunction

    // Stimulus + expectation producer for DUT A
    initial begin : drive_a
        int e;
        e = 0;
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            if (cyc < 3 || (cyc >= RST_AT && cyc < RST_AT + 3)) begin
                rst_n = 1'b0;
                ce    = 1'($urandom);
                e     = 0;
                q.push_back(reset_exp());
            end else begin
                rst_n = 1'b1;
                if (cyc == 3) rst_b_n = 1'b1;
                ce   = (cyc < 500) ? 1'(cyc % 2) : ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 49) == 0) tp = ~tp;
                r_in = (e >= LAT) ? 8'((e - LAT) % HT) : 8'h00;
                g_in = 8'($urandom);
                b_in = 8'($urandom);
                g_hist[e]  = g_in;
                b_hist[e]  = b_in;
                tp_hist[e] = tp;
                q.push_back(model(e, ce));
                if (ce) e++;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("b_checker_done", 32'(done_b), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Monitor for DUT A: one expectation per clock, sampled mid-cycle
    initial begin : mon_a
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("a_r",  32'(a_r),  32'(x.r));
                chk("a_g",  32'(a_g),  32'(x.g));
                chk("a_b",  32'(a_b),  32'(x.b));
                chk("a_hsync", 32'(a_hs), 32'(x.hs));
                chk("a_vsync", 32'(a_vs), 32'(x.vs));
                chk("a_de", 32'(a_de), 32'(x.de));
                chk("a_next_x", 32'(a_nx), 32'(x.nx));
                chk("a_next_y", 32'(a_ny), 32'(x.ny));
                chk("a_next_active", 32'(a_na), 32'(x.na));
                chk("a_frame_start", 32'(a_fs), 32'(x.fs));
                chk("a_line_start",  32'(a_ls), 32'(x.ls));
            end
        end
    end

    // DUT B: reset values, then one line of default timing measured in clocks
    initial begin : chk_b
        int   t_de0, t_de1, t_hsf, t_hsr, de_cnt;
        logic pde, phs;
        t_de0 = -1; t_de1 = -1; t_hsf = -1; t_hsr = -1; de_cnt = 0;
        pde = 1'b0; phs = 1'b1;
        @(negedge clk);
        chk("b_rst_hsync", 32'(b_hs), 32'd1);
        chk("b_rst_vsync", 32'(b_vs), 32'd1);
        chk("b_rst_de",    32'(b_de), 32'd0);
        chk("b_rst_rgb",   32'({b_r, b_g, b_b}), 32'd0);
        chk("b_rst_next",  32'({b_nx, b_ny, b_na, b_fs, b_ls}), 32'd0);
        @(posedge rst_b_n);
        for (int t = 0; t < 1700; t++) begin
            @(negedge clk);
            if (t == 0) chk("b_first_frame_start", 32'(b_fs), 32'd1);
            if (b_de && !pde) begin
                if (t_de0 < 0) t_de0 = t;
                else if (t_de1 < 0) t_de1 = t;
            end
            if (t_de0 >= 0 && t_de1 < 0 && b_de) de_cnt++;
            if (t_de0 >= 0 && t_hsf < 0 && !b_hs && phs) t_hsf = t;
            if (t_hsf >= 0 && t_hsr < 0 && b_hs && !phs) t_hsr = t;
            pde = b_de;
            phs = b_hs;
        end
        chk("b_first_de_cycle", 32'(t_de0), 32'd2);
        chk("b_hsync_offset",   32'(t_hsf - t_de0), 32'd656);
        chk("b_hsync_width",    32'(t_hsr - t_hsf), 32'd96);
        chk("b_line_period",    32'(t_de1 - t_de0), 32'd800);
        chk("b_de_per_line",    32'(de_cnt), 32'd640);
        done_b = 1'b1;
    end

endmodule

// File: doc/mod_vga_timing_encoder.md
MOD_VGA_TIMING_ENCODER -- requirements
Module: mod_vga_timing_encoder

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal front porch/sync/back porch in pixels.
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical timing in lines.
REQ-004 SHALL have parameters HSYNC_POL/VSYNC_POL, default 0/0, asserted sync level (0 = active-low).
REQ-005 SHALL have parameter COLOR_W, default 8, bits per colour channel.
REQ-006 SHALL have parameter PIPE_LAT, default 1, range 0..7, cycles the upstream pixel source needs from coordinate to colour.
REQ-007 SHALL have port in_clk, input, 1, pixel clock; the block has one clock.
REQ-008 SHALL have port in_rst_n, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port in_pix_ce, input, 1, pixel clock enable; all timing state advances only when high.
REQ-010 SHALL have ports in_vga_r/g/b, input, COLOR_W each, pixel colour for the coordinate issued PIPE_LAT enabled cycles earlier.
REQ-011 SHALL have port in_test_pattern, input, 1, test pattern select (see Configuration).
REQ-012 SHALL have ports out_vga_r/g/b, output, COLOR_W each, registered colour.
REQ-013 SHALL have ports out_vga_hsync/out_vga_vsync/out_vga_de, output, 1 each, aligned sync and data-enable.
REQ-014 SHALL have ports out_vga_next_x/out_vga_next_y, output, 12 each, coordinate being requested.
REQ-015 SHALL have ports out_vga_next_active, out_frame_start, out_line_start, output, 1 each.

Function
REQ-016 SHALL keep h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1 (H_TOTAL = sum of H_*, same for V); each line is active, FP, sync, BP in that order.
REQ-017 SHALL increment h_cnt on each cycle with in_pix_ce high, wrap to 0 after H_TOTAL-1, and increment v_cnt (wrapping after V_TOTAL-1) on the same cycle h_cnt wraps.
REQ-018 SHALL drive next_x = h_cnt, next_y = v_cnt, next_active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
REQ-019 SHALL pulse out_line_start for one cycle when h_cnt==0 and in_pix_ce high; out_frame_start likewise when also v_cnt==0.
REQ-020 SHALL delay hsync, vsync and active through a PIPE_LAT+1 stage shift register advanced only by in_pix_ce, so that outputs correspond to the colour sampled at that point.
REQ-021 SHALL assert hsync (level HSYNC_POL) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], vsync likewise on v_cnt; otherwise drive the inverse level.
REQ-022 SHALL register out_vga_r/g/b from in_vga_r/g/b when the delayed active bit is 1, else 0; out_vga_de equals the delayed active bit.
REQ-023 SHALL hold all registers, outputs and pulses (pulses low) when in_pix_ce is low.
REQ-024 SHALL produce total latency PIPE_LAT+1 enabled cycles from a coordinate on next_x/next_y to its pixel on out_vga_*.

Reset
REQ-025 SHALL, while in_rst_n low, force h_cnt=0, v_cnt=0, shift stages inactive, colours 0, de 0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, line/frame pulses 0, next_active 0.
REQ-026 SHALL, on reset release mid-frame, restart at (0,0) with out_frame_start on the first enabled cycle; no partial pipeline data emitted.

Configuration
REQ-027 SHALL, with macro VGA_TEST_PATTERN_EN defined, replace in_vga_* by 8 vertical colour bars (width H_ACTIVE/8, order white, yellow, cyan, green, magenta, red, blue, black, full-scale channels) when in_test_pattern is high, with identical latency.
REQ-028 SHALL, without VGA_TEST_PATTERN_EN, ignore in_test_pattern and contain no pattern logic.

Verification
REQ-029 SHALL test: defaults, in_pix_ce=1, two frames -> 800 cycles/line, 525 lines/frame, hsync low exactly 96 cycles starting 656 cycles after de rises, vsync low 2 lines, de high 640x480.
REQ-030 SHALL test: PIPE_LAT=3, in_vga_r fed next_x[7:0] delayed 3 cycles -> out_vga_r equals x of pixel on every de cycle, 0 in blanking.
REQ-031 SHALL test: in_pix_ce toggled 1010... -> line takes 1600 clocks, outputs stable on disabled cycles.
REQ-032 SHALL test: in_rst_n pulsed low at (300,200) -> outputs immediately at reset values, out_frame_start one enabled cycle after release.
REQ-033 SHALL test: HSYNC_POL=1, VSYNC_POL=1, H_ACTIVE=320, V_ACTIVE=240 -> sync pulses high, de 320x240, H_TOTAL 480.
REQ-034 SHALL test: VGA_TEST_PATTERN_EN defined, in_test_pattern=1 -> pixel x=0 is all-ones, x=80 is (FF,FF,00), x=639 is 0.
